reset_sched: RTL and testbench
==============================

# reset_sched

Controller sitting between the host configuration registers and the pixel-array reset pulse generator. It accepts reset-timing configurations through a valid/ready handshake and keeps a pending copy of the next one. It applies new timing only at a safe point in the period (start of the low phase), counts delivered reset pulses, and supports continuous and fixed-count burst modes. When stopped, it parks the generator in its never-reset state (high time 16'hFFFF).

## Interface
- TIME_W, 16, width of high/low time values (generator time width)
- CNT_W, 16, width of burst target and period counter

- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cfg_valid  in  1  host presents a configuration
- cfg_ready  out  1  controller accepts the configuration this cycle
- cfg_mode  in  2  00 stop, 01 continuous, 10 burst, 11 reserved (treated as stop)
- cfg_high  in  TIME_W  requested high time (us ticks)
- cfg_low  in  TIME_W  requested low time (us ticks)
- cfg_count  in  CNT_W  burst pulse count
- gen_out  in  1  pulse generator output, monitored
- gen_rst  out  1  active-high synchronous reset to the generator
- gen_high_time  out  TIME_W  high time driven to the generator
- gen_low_time  out  TIME_W  low time driven to the generator
- period_count  out  CNT_W  pulses delivered since the last applied configuration
- busy  out  1  high in RESTART/RUN
- done  out  1  one-cycle pulse when a burst completes or a stop takes effect

## Operation
- Transfer occurs when cfg_valid && cfg_ready. Fields are captured into the pending registers (mode, high, low, count) and pend=1.
- Edge detect: gen_out_d is gen_out registered. fall = gen_out_d & ~gen_out. fall is masked in RESTART and on the first RUN cycle.
- States:
  - IDLE: gen_high_time=16'hFFFF, gen_low_time=0, gen_rst=0, cfg_ready=1. A transfer with mode 01/10 loads the active registers, clears period_count, and goes to RESTART. A transfer with mode 00/11 stays in IDLE and pulses done.
  - RESTART: gen_rst=1 for exactly 2 cycles, cfg_ready=0, then RUN.
  - RUN: cfg_ready = ~pend.
    - On fall: period_count increments (saturates at all-ones).
    - If pend on the same fall: apply the pending config. Active mode/high/low/count take the pending values, period_count is cleared (the pending clear wins over the increment), and pend=0. A pending stop goes to IDLE with done=1. The generator is not restarted; it latches the new times at its next period.
    - Else, in burst mode, if the incremented count reaches active count: go to IDLE and pulse done.
  - Stuck rule: if the active high is 0 or 16'hFFFF, no fall ever occurs. In that case, any pend is applied on the next cycle via RESTART (stop goes directly to IDLE).
- Burst with cfg_count=0 is treated as count 1.
- Reserved mode 11 is treated identically to stop.

## Timing
- Reset (reset=0) values: gen_rst=1, gen_high_time=16'hFFFF, gen_low_time=0, period_count=0, busy=0, done=0, cfg_ready=0, pend=0, state=IDLE. After reset is released: gen_rst=0 and cfg_ready=1 on the next cycle.
- Latency from an IDLE transfer edge to gen_rst=1 is 1 cycle. gen_rst is held 2 cycles. busy is asserted from the first RESTART cycle.
- fall is registered 1 cycle after gen_out drops. Outputs update at the clock edge after fall is seen, so the new times are stable for the whole low phase, well before the generator's latch state.
- done asserts in the same cycle the state becomes IDLE. From that cycle, gen_high_time is 16'hFFFF.
- A transfer in the same cycle as a fall that applies an older pend cannot occur, because cfg_ready=0 while pend=1.
- Reset asserted mid-RUN returns to the reset values in 1 cycle. No done is generated.
- All arithmetic is unsigned. period_count does not wrap.

## Test plan
- Continuous: after reset, send mode=01, high=2, low=98 -> gen_rst high for 2 cycles, gen_high_time=2, gen_low_time=98. period_count increments once per pulse; 5 pulses give period_count=5.
- Burst: send mode=10, high=3, low=10, count=4 -> exactly 4 gen_out pulses. done pulses once on the 4th fall. gen_high_time=16'hFFFF afterward and busy=0.
- Reconfigure mid-run: while running high=2/low=98, send high=5/low=50 during a high phase -> cfg_ready drops. Outputs change on the cycle after the next fall, period_count resets to 0, and cfg_ready returns to 1.
- Stuck/stop: run with high=0 (gen_out constantly 1), then send stop -> IDLE next cycle, done=1, gen_high_time=16'hFFFF.
- Edge cases: burst count=0 -> one pulse, then done. Drop reset to 0 mid-burst -> all outputs take reset values in 1 cycle, with no done pulse.

Source files
------------

// File: rtl/reset_sched.sv
// reset_sched: hands host reset-timing configurations to the pixel-array reset pulse
// generator, switching timing only at the start of a low phase, with continuous and burst modes.
module reset_sched #(
  parameter int TIME_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [TIME_W-1:0] cfg_high,
  input  logic [TIME_W-1:0] cfg_low,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              gen_out,
  output logic              gen_rst,
  output logic [TIME_W-1:0] gen_high_time,
  output logic [TIME_W-1:0] gen_low_time,
  output logic [CNT_W-1:0]  period_count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTART = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [1:0]        MODE_CONT  = 2'b01;
  localparam logic [1:0]        MODE_BURST = 2'b10;
  localparam logic [TIME_W-1:0] TIME_MAX   = {TIME_W{1'b1}};
  localparam logic [TIME_W-1:0] TIME_ZERO  = {TIME_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stop (00) and reserved (11) both park the generator.
  function automatic logic is_run_mode(input logic [1:0] mode);
    return (mode == MODE_CONT) || (mode == MODE_BURST);
  endfunction

  function automatic logic [CNT_W-1:0] burst_target(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_ZERO) ? CNT_ONE : cnt;
  endfunction

  state_t              state_r, state_nxt;
  logic                rst_cnt_r, rst_cnt_nxt;
  logic                first_run_r, first_run_nxt;
  logic                gen_out_d_r;
  logic                pend_r, pend_nxt;
  logic [1:0]          pend_mode_r, pend_mode_nxt;
  logic [TIME_W-1:0]   pend_high_r, pend_high_nxt;
  logic [TIME_W-1:0]   pend_low_r, pend_low_nxt;
  logic [CNT_W-1:0]    pend_count_r, pend_count_nxt;
  logic [1:0]          act_mode_r, act_mode_nxt;
  logic [TIME_W-1:0]   act_high_r, act_high_nxt;
  logic [TIME_W-1:0]   act_low_r, act_low_nxt;
  logic [CNT_W-1:0]    act_target_r, act_target_nxt;
  logic [CNT_W-1:0]    period_count_r, period_nxt;
  logic                done_r, done_nxt;
  logic                cfg_ready_r, cfg_ready_nxt;
  logic                gen_rst_r, gen_rst_nxt;
  logic                busy_r, busy_nxt;
  logic [TIME_W-1:0]   gen_high_r, gen_high_nxt;
  logic [TIME_W-1:0]   gen_low_r, gen_low_nxt;

  logic                xfer_s, fall_s, stuck_s, apply_s;
  logic [CNT_W-1:0]    cnt_inc_s;

  // First RUN cycle is masked: gen_out_d still reflects the generator while it was held in reset.
  assign xfer_s    = cfg_valid & cfg_ready_r;
  assign fall_s    = gen_out_d_r & ~gen_out & (state_r == ST_RUN) & ~first_run_r;
  assign stuck_s   = (act_high_r == TIME_ZERO) | (act_high_r == TIME_MAX);
  assign apply_s   = pend_r & (fall_s | stuck_s);
  assign cnt_inc_s = (period_count_r == CNT_MAX) ? period_count_r : period_count_r + CNT_ONE;

  // State, datapath and registered-output update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      rst_cnt_r      <= 1'b0;
      first_run_r    <= 1'b0;
      gen_out_d_r    <= 1'b0;
      pend_r         <= 1'b0;
      pend_mode_r    <= 2'b00;
      pend_high_r    <= TIME_ZERO;
      pend_low_r     <= TIME_ZERO;
      pend_count_r   <= CNT_ZERO;
      act_mode_r     <= 2'b00;
      act_high_r     <= TIME_MAX;
      act_low_r      <= TIME_ZERO;
      act_target_r   <= CNT_ONE;
      period_count_r <= CNT_ZERO;
      done_r         <= 1'b0;
      cfg_ready_r    <= 1'b0;
      gen_rst_r      <= 1'b1;
      busy_r         <= 1'b0;
      gen_high_r     <= TIME_MAX;
      gen_low_r      <= TIME_ZERO;
    end else begin
      state_r        <= state_nxt;
      rst_cnt_r      <= rst_cnt_nxt;
      first_run_r    <= first_run_nxt;
      gen_out_d_r    <= gen_out;
      pend_r         <= pend_nxt;
      pend_mode_r    <= pend_mode_nxt;
      pend_high_r    <= pend_high_nxt;
      pend_low_r     <= pend_low_nxt;
      pend_count_r   <= pend_count_nxt;
      act_mode_r     <= act_mode_nxt;
      act_high_r     <= act_high_nxt;
      act_low_r      <= act_low_nxt;
      act_target_r   <= act_target_nxt;
      period_count_r <= period_nxt;
      done_r         <= done_nxt;
      cfg_ready_r    <= cfg_ready_nxt;
      gen_rst_r      <= gen_rst_nxt;
      busy_r         <= busy_nxt;
      gen_high_r     <= gen_high_nxt;
      gen_low_r      <= gen_low_nxt;
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_nxt      = state_r;
    rst_cnt_nxt    = 1'b0;
    first_run_nxt  = 1'b0;
    pend_nxt       = pend_r;
    pend_mode_nxt  = pend_mode_r;
    pend_high_nxt  = pend_high_r;
    pend_low_nxt   = pend_low_r;
    pend_count_nxt = pend_count_r;
    act_mode_nxt   = act_mode_r;
    act_high_nxt   = act_high_r;
    act_low_nxt    = act_low_r;
    act_target_nxt = act_target_r;
    period_nxt     = period_count_r;
    done_nxt       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          if (is_run_mode(cfg_mode)) begin
            act_mode_nxt   = cfg_mode;
            act_high_nxt   = cfg_high;
            act_low_nxt    = cfg_low;
            act_target_nxt = burst_target(cfg_count);
            period_nxt     = CNT_ZERO;
            state_nxt      = ST_RESTART;
          end else begin
            done_nxt = 1'b1;
          end
        end else if (pend_r) begin
          // A transfer that landed on the same edge a burst finished is served here.
          pend_nxt = 1'b0;
          if (is_run_mode(pend_mode_r)) begin
            act_mode_nxt   = pend_mode_r;
            act_high_nxt   = pend_high_r;
            act_low_nxt    = pend_low_r;
            act_target_nxt = burst_target(pend_count_r);
            period_nxt     = CNT_ZERO;
            state_nxt      = ST_RESTART;
          end else begin
            done_nxt = 1'b1;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RESTART: begin
        if (rst_cnt_r) begin
          state_nxt     = ST_RUN;
          first_run_nxt = 1'b1;
        end else begin
          rst_cnt_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (xfer_s) begin
          pend_nxt       = 1'b1;
          pend_mode_nxt  = cfg_mode;
          pend_high_nxt  = cfg_high;
          pend_low_nxt   = cfg_low;
          pend_count_nxt = cfg_count;
        end else begin
          pend_nxt = pend_r;
        end
        if (apply_s) begin
          act_mode_nxt   = pend_mode_r;
          act_high_nxt   = pend_high_r;
          act_low_nxt    = pend_low_r;
          act_target_nxt = burst_target(pend_count_r);
          period_nxt     = CNT_ZERO;
          pend_nxt       = 1'b0;
          if (!is_run_mode(pend_mode_r)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else if (!fall_s) begin
            state_nxt = ST_RESTART;
          end else begin
            state_nxt = ST_RUN;
          end
        end else if (fall_s) begin
          period_nxt = cnt_inc_s;
          if ((act_mode_r == MODE_BURST) && (cnt_inc_s == act_target_r)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_RUN;
          end
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state, registered above.
  always_comb begin
    gen_rst_nxt   = 1'b0;
    busy_nxt      = 1'b0;
    cfg_ready_nxt = 1'b0;
    gen_high_nxt  = TIME_MAX;
    gen_low_nxt   = TIME_ZERO;
    case (state_nxt)
      ST_IDLE: begin
        cfg_ready_nxt = ~pend_nxt;
      end
      ST_RESTART: begin
        gen_rst_nxt  = 1'b1;
        busy_nxt     = 1'b1;
        gen_high_nxt = act_high_nxt;
        gen_low_nxt  = act_low_nxt;
      end
      ST_RUN: begin
        busy_nxt      = 1'b1;
        cfg_ready_nxt = ~pend_nxt;
        gen_high_nxt  = act_high_nxt;
        gen_low_nxt   = act_low_nxt;
      end
      default: begin
        cfg_ready_nxt = 1'b0;
      end
    endcase
  end

  assign cfg_ready     = cfg_ready_r;
  assign gen_rst       = gen_rst_r;
  assign gen_high_time = gen_high_r;
  assign gen_low_time  = gen_low_r;
  assign period_count  = period_count_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_reset_sched.sv
// Directed self-checking bench for reset_sched; the bench drives gen_out itself
// in place of the pulse generator.
module tb_reset_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_high;
  logic [15:0] cfg_low;
  logic [15:0] cfg_count;
  logic        gen_out;
  logic        gen_rst;
  logic [15:0] gen_high_time;
  logic [15:0] gen_low_time;
  logic [15:0] period_count;
  logic        busy;
  logic        done;

  int chk_cnt  = 0;
  int fail_cnt = 0;
  int done_cnt = 0;
  int base;

  reset_sched dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_count(cfg_count),
    .gen_out(gen_out), .gen_rst(gen_rst), .gen_high_time(gen_high_time),
    .gen_low_time(gen_low_time), .period_count(period_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic send(input logic [1:0] m, input logic [15:0] h, input logic [15:0] l, input logic [15:0] c);
    cfg_valid = 1'b1; cfg_mode = m; cfg_high = h; cfg_low = l; cfg_count = c;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    gen_out = 1'b1;
    repeat (hi) @(negedge clk);
    gen_out = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; cfg_valid = 1'b0; gen_out = 1'b0;
    cfg_mode = 2'b00; cfg_high = 16'd0; cfg_low = 16'd0; cfg_count = 16'd0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (gen_rst !== 1'b1) begin fail_cnt++; $display("FAIL rst_gen_rst: got %0h expected 1", gen_rst); end
    chk_cnt++; if (gen_high_time !== 16'hFFFF) begin fail_cnt++; $display("FAIL rst_high: got %0h expected ffff", gen_high_time); end
    chk_cnt++; if (gen_low_time !== 16'h0000) begin fail_cnt++; $display("FAIL rst_low: got %0h expected 0", gen_low_time); end
    chk_cnt++; if (period_count !== 16'd0) begin fail_cnt++; $display("FAIL rst_count: got %0d expected 0", period_count); end
    chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_busy: got %0h expected 0", busy); end
    chk_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL rst_done: got %0h expected 0", done); end
    chk_cnt++; if (cfg_ready !== 1'b0) begin fail_cnt++; $display("FAIL rst_ready: got %0h expected 0", cfg_ready); end
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++; if (gen_rst !== 1'b0) begin fail_cnt++; $display("FAIL rel_gen_rst: got %0h expected 0", gen_rst); end
    chk_cnt++; if (cfg_ready !== 1'b1) begin fail_cnt++; $display("FAIL rel_ready: got %0h expected 1", cfg_ready); end
  endtask

  task automatic test_continuous;
    send(2'b01, 16'd2, 16'd98, 16'd0);
    chk_cnt++; if (gen_rst !== 1'b1) begin fail_cnt++; $display("FAIL cont_rst1: got %0h expected 1", gen_rst); end
    chk_cnt++; if (busy !== 1'b1) begin fail_cnt++; $display("FAIL cont_busy: got %0h expected 1", busy); end
    chk_cnt++; if (cfg_ready !== 1'b0) begin fail_cnt++; $display("FAIL cont_ready_restart: got %0h expected 0", cfg_ready); end
    chk_cnt++; if (gen_high_time !== 16'd2) begin fail_cnt++; $display("FAIL cont_high: got %0d expected 2", gen_high_time); end
    chk_cnt++; if (gen_low_time !== 16'd98) begin fail_cnt++; $display("FAIL cont_low: got %0d expected 98", gen_low_time); end
    @(negedge clk);
    chk_cnt++; if (gen_rst !== 1'b1) begin fail_cnt++; $display("FAIL cont_rst2: got %0h expected 1", gen_rst); end
    @(negedge clk);
    chk_cnt++; if (gen_rst !== 1'b0) begin fail_cnt++; $display("FAIL cont_rst3: got %0h expected 0", gen_rst); end
    chk_cnt++; if (cfg_ready !== 1'b1) begin fail_cnt++; $display("FAIL cont_ready_run: got %0h expected 1", cfg_ready); end
    pulse(2, 3);
    chk_cnt++; if (period_count !== 16'd1) begin fail_cnt++; $display("FAIL cont_count1: got %0d expected 1", period_count); end
    repeat (4) pulse(2, 3);
    chk_cnt++; if (period_count !== 16'd5) begin fail_cnt++; $display("FAIL cont_count5: got %0d expected 5", period_count); end
  endtask

  task automatic test_reconfig;
    gen_out = 1'b1;
    @(negedge clk);
    send(2'b01, 16'd5, 16'd50, 16'd0);
    chk_cnt++; if (cfg_ready !== 1'b0) begin fail_cnt++; $display("FAIL recfg_ready_drop: got %0h expected 0", cfg_ready); end
    chk_cnt++; if (gen_high_time !== 16'd2) begin fail_cnt++; $display("FAIL recfg_high_hold: got %0d expected 2", gen_high_time); end
    gen_out = 1'b0;
    @(negedge clk);
    chk_cnt++; if (gen_high_time !== 16'd5) begin fail_cnt++; $display("FAIL recfg_high: got %0d expected 5", gen_high_time); end
    chk_cnt++; if (gen_low_time !== 16'd50) begin fail_cnt++; $display("FAIL recfg_low: got %0d expected 50", gen_low_time); end
    chk_cnt++; if (period_count !== 16'd0) begin fail_cnt++; $display("FAIL recfg_count: got %0d expected 0", period_count); end
    chk_cnt++; if (cfg_ready !== 1'b1) begin fail_cnt++; $display("FAIL recfg_ready_back: got %0h expected 1", cfg_ready); end
    pulse(2, 3);
    chk_cnt++; if (period_count !== 16'd1) begin fail_cnt++; $display("FAIL recfg_count1: got %0d expected 1", period_count); end
    // Pending stop in a running configuration takes effect at the next fall.
    send(2'b00, 16'd0, 16'd0, 16'd0);
    chk_cnt++; if (busy !== 1'b1) begin fail_cnt++; $display("FAIL pstop_busy: got %0h expected 1", busy); end
    gen_out = 1'b1;
    repeat (2) @(negedge clk);
    gen_out = 1'b0;
    @(negedge clk);
    chk_cnt++; if (done !== 1'b1) begin fail_cnt++; $display("FAIL pstop_done: got %0h expected 1", done); end
    chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL pstop_idle: got %0h expected 0", busy); end
    chk_cnt++; if (gen_high_time !== 16'hFFFF) begin fail_cnt++; $display("FAIL pstop_high: got %0h expected ffff", gen_high_time); end
    chk_cnt++; if (period_count !== 16'd0) begin fail_cnt++; $display("FAIL pstop_count: got %0d expected 0", period_count); end
    @(negedge clk);
    chk_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL pstop_done_pulse: got %0h expected 0", done); end
  endtask

  task automatic test_burst;
    send(2'b10, 16'd3, 16'd10, 16'd4);
    chk_cnt++; if (gen_high_time !== 16'd3) begin fail_cnt++; $display("FAIL burst_high: got %0d expected 3", gen_high_time); end
    chk_cnt++; if (gen_low_time !== 16'd10) begin fail_cnt++; $display("FAIL burst_low: got %0d expected 10", gen_low_time); end
    repeat (2) @(negedge clk);
    base = done_cnt;
    repeat (3) pulse(3, 2);
    chk_cnt++; if (period_count !== 16'd3) begin fail_cnt++; $display("FAIL burst_count3: got %0d expected 3", period_count); end
    chk_cnt++; if (busy !== 1'b1) begin fail_cnt++; $display("FAIL burst_busy3: got %0h expected 1", busy); end
    gen_out = 1'b1;
    repeat (3) @(negedge clk);
    gen_out = 1'b0;
    @(negedge clk);
    chk_cnt++; if (done !== 1'b1) begin fail_cnt++; $display("FAIL burst_done: got %0h expected 1", done); end
    chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL burst_idle: got %0h expected 0", busy); end
    chk_cnt++; if (gen_high_time !== 16'hFFFF) begin fail_cnt++; $display("FAIL burst_park: got %0h expected ffff", gen_high_time); end
    chk_cnt++; if (period_count !== 16'd4) begin fail_cnt++; $display("FAIL burst_count4: got %0d expected 4", period_count); end
    pulse(3, 2);
    chk_cnt++; if (period_count !== 16'd4) begin fail_cnt++; $display("FAIL burst_idle_count: got %0d expected 4", period_count); end
    chk_cnt++; if ((done_cnt - base) !== 1) begin fail_cnt++; $display("FAIL burst_done_once: got %0d expected 1", done_cnt - base); end
  endtask

  task automatic test_stuck_stop;
    gen_out = 1'b1;
    send(2'b01, 16'd0, 16'd10, 16'd0);
    repeat (3) @(negedge clk);
    chk_cnt++; if (busy !== 1'b1) begin fail_cnt++; $display("FAIL stuck_busy: got %0h expected 1", busy); end
    chk_cnt++; if (gen_high_time !== 16'd0) begin fail_cnt++; $display("FAIL stuck_high: got %0d expected 0", gen_high_time); end
    send(2'b00, 16'd0, 16'd0, 16'd0);
    chk_cnt++; if (cfg_ready !== 1'b0) begin fail_cnt++; $display("FAIL stuck_pend: got %0h expected 0", cfg_ready); end
    chk_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL stuck_early_done: got %0h expected 0", done); end
    @(negedge clk);
    chk_cnt++; if (done !== 1'b1) begin fail_cnt++; $display("FAIL stuck_done: got %0h expected 1", done); end
    chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL stuck_idle: got %0h expected 0", busy); end
    chk_cnt++; if (gen_high_time !== 16'hFFFF) begin fail_cnt++; $display("FAIL stuck_park: got %0h expected ffff", gen_high_time); end
    chk_cnt++; if (cfg_ready !== 1'b1) begin fail_cnt++; $display("FAIL stuck_ready: got %0h expected 1", cfg_ready); end
    @(negedge clk);
    gen_out = 1'b0;
    // Reserved mode behaves as stop while idle.
    send(2'b11, 16'd7, 16'd7, 16'd7);
    chk_cnt++; if (done !== 1'b1) begin fail_cnt++; $display("FAIL rsvd_done: got %0h expected 1", done); end
    chk_cnt++; if (gen_rst !== 1'b0) begin fail_cnt++; $display("FAIL rsvd_gen_rst: got %0h expected 0", gen_rst); end
    chk_cnt++; if (gen_high_time !== 16'hFFFF) begin fail_cnt++; $display("FAIL rsvd_park: got %0h expected ffff", gen_high_time); end
  endtask

  task automatic test_burst_zero;
    @(negedge clk);
    send(2'b10, 16'd3, 16'd2, 16'd0);
    repeat (2) @(negedge clk);
    gen_out = 1'b1;
    repeat (3) @(negedge clk);
    gen_out = 1'b0;
    @(negedge clk);
    chk_cnt++; if (done !== 1'b1) begin fail_cnt++; $display("FAIL bz_done: got %0h expected 1", done); end
    chk_cnt++; if (period_count !== 16'd1) begin fail_cnt++; $display("FAIL bz_count: got %0d expected 1", period_count); end
    chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL bz_idle: got %0h expected 0", busy); end
  endtask

  task automatic test_reset_mid_burst;
    repeat (2) @(negedge clk);
    send(2'b10, 16'd3, 16'd2, 16'd4);
    repeat (2) @(negedge clk);
    base = done_cnt;
    repeat (2) pulse(3, 2);
    chk_cnt++; if (period_count !== 16'd2) begin fail_cnt++; $display("FAIL mid_count: got %0d expected 2", period_count); end
    gen_out = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++; if (gen_rst !== 1'b1) begin fail_cnt++; $display("FAIL mid_gen_rst: got %0h expected 1", gen_rst); end
    chk_cnt++; if (gen_high_time !== 16'hFFFF) begin fail_cnt++; $display("FAIL mid_high: got %0h expected ffff", gen_high_time); end
    chk_cnt++; if (gen_low_time !== 16'h0000) begin fail_cnt++; $display("FAIL mid_low: got %0h expected 0", gen_low_time); end
    chk_cnt++; if (period_count !== 16'd0) begin fail_cnt++; $display("FAIL mid_count0: got %0d expected 0", period_count); end
    chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL mid_busy: got %0h expected 0", busy); end
    chk_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL mid_done: got %0h expected 0", done); end
    chk_cnt++; if (cfg_ready !== 1'b0) begin fail_cnt++; $display("FAIL mid_ready: got %0h expected 0", cfg_ready); end
    gen_out = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++; if (cfg_ready !== 1'b1) begin fail_cnt++; $display("FAIL mid_rel_ready: got %0h expected 1", cfg_ready); end
    chk_cnt++; if (gen_rst !== 1'b0) begin fail_cnt++; $display("FAIL mid_rel_gen_rst: got %0h expected 0", gen_rst); end
    repeat (2) @(negedge clk);
    chk_cnt++; if ((done_cnt - base) !== 0) begin fail_cnt++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt - base); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_reconfig();
    test_burst();
    test_stuck_stop();
    test_burst_zero();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
